// File: rtl/seq_divider_ctrl.sv
// Iterative unsigned restoring divider: one shared WIDTH+1 bit adder, one quotient bit per clock.
// start/busy/done handshake; results held until the next accepted start.

module seq_divider_adder #(
  parameter int N = 9
) (
  input  logic signed [N-1:0] a,
  input  logic signed [N-1:0] b,
  input  logic                cin,
  output logic signed [N-1:0] sum
);
  assign sum = a + b + {{(N-1){1'b0}}, cin};
endmodule

module seq_divider_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic [1:0]       state_dbg
);
  localparam int CW = $clog2(WIDTH + 1);

  // Handshake: start is taken on a rising edge only in IDLE or DONE; busy marks RUN,
  // done is a one-cycle pulse from which quotient/remainder/div_by_zero are valid.
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t           state;
  logic [WIDTH:0]   rem;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] d;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   s;
  logic [WIDTH:0]   sum;

  assign s = {rem[WIDTH-1:0], q[WIDTH-1]};

  // Always connected; its output only matters while in RUN.
  seq_divider_adder #(.N(WIDTH + 1)) u_adder (
    .a   (s),
    .b   (~{1'b0, d}),
    .cin (1'b1),
    .sum (sum)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      rem         <= '0;
      q           <= '0;
      d           <= '0;
      cnt         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            d           <= divisor;
            cnt         <= CW'(WIDTH);
            div_by_zero <= (divisor == '0);
            if (divisor == '0) begin
              // Defined divide-by-zero result, no iterations.
              q     <= '1;
              rem   <= {1'b0, dividend};
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              q     <= dividend;
              rem   <= '0;
              state <= RUN;
              busy  <= 1'b1;
              done  <= 1'b0;
            end
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
          end
        end
        RUN: begin
          // sum[WIDTH] set means s < d: restore by keeping s.
          rem <= sum[WIDTH] ? s : sum;
          q   <= {q[WIDTH-2:0], ~sum[WIDTH]};
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  assign quotient  = q;
  assign remainder = rem[WIDTH-1:0];
  assign state_dbg = state;

endmodule
